// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op and state encodings shared by the iterative mul/div unit
package muldiv_pkg;
  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_MLA  = 2'b01;
  localparam logic [1:0] OP_UDIV = 2'b10;
  localparam logic [1:0] OP_SDIV = 2'b11;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;
  function automatic logic is_div(input logic [1:0] op);
    return op[1];
  endfunction
endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational shift-add / restoring-divide iteration
// Ports: div selects divide step; acc is accumulator or partial remainder;
// mc is multiplicand or divisor; mp is multiplier or dividend/quotient.
// Outputs are the next register values plus the produced quotient bit q
// (mp_n leaves its LSB zero on a divide so the caller can insert q).
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             div,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] mc,
  input  logic [WIDTH-1:0] mp,
  output logic [WIDTH-1:0] acc_n,
  output logic [WIDTH-1:0] mc_n,
  output logic [WIDTH-1:0] mp_n,
  output logic             q
);
  logic [WIDTH:0]   r;
  logic [WIDTH-1:0] d;
  always_comb begin
    r     = {acc, mp[WIDTH-1]};
    d     = r[WIDTH-1:0] - mc;
    q     = div && (r >= {1'b0, mc});
    acc_n = div ? (q ? d : r[WIDTH-1:0]) : (mp[0] ? acc + mc : acc);
    mc_n  = div ? mc : mc << 1;
    mp_n  = div ? mp << 1 : mp >> 1;
  end
endmodule

// File: rtl/muldiv_iter.sv
// muldiv_iter: iterative MUL / MLA / UDIV / SDIV unit with start/busy/done handshake
// Ports: clk, reset (sync, active-high); start pulse sampled in IDLE; op selects
// 00 MUL, 01 MLA, 10 UDIV, 11 SDIV; a, b, c operands (c used by MLA only);
// busy, done (one-cycle pulse), result (low product bits or quotient),
// div_zero (set with done for a divide by zero, cleared on the next accept).
// Optional macro MULDIV_EARLY_EXIT_EN: MUL/MLA leave RUN as soon as the
// remaining multiplier is zero.
// busy and done are registered from the state, so they trail the FSM by one
// cycle: done appears after edge k+WIDTH+2 and busy spans WIDTH+1 cycles.
module muldiv_iter
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             div_zero
);
  localparam int CW = $clog2(WIDTH);
  state_t           state, state_n;
  logic [CW-1:0]    cnt;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] acc, mc, mp, acc_s, mc_s, mp_s, fix_res;
  logic             sa, sb, dz, q_s, accept, run_end, sdiv_in;
  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .div   (is_div(op_q)),
    .acc   (acc),
    .mc    (mc),
    .mp    (mp),
    .acc_n (acc_s),
    .mc_n  (mc_s),
    .mp_n  (mp_s),
    .q     (q_s)
  );
  assign accept  = state == S_IDLE && start;
  assign sdiv_in = op == OP_SDIV;
`ifdef MULDIV_EARLY_EXIT_EN
  assign run_end = cnt == CW'(WIDTH - 1) || (!is_div(op_q) && mp_s == '0);
`else
  assign run_end = cnt == CW'(WIDTH - 1);
`endif
  always_comb begin
    state_n = state == S_IDLE ? (start ? S_RUN : S_IDLE) :
              state == S_RUN  ? (run_end ? S_FIX : S_RUN) :
              state == S_FIX  ? S_DONE : S_IDLE;
    fix_res = dz ? '0 : !is_div(op_q) ? acc : (op_q == OP_SDIV && (sa ^ sb)) ? -mp : mp;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      op_q     <= OP_MUL;
      acc      <= '0;
      mc       <= '0;
      mp       <= '0;
      sa       <= 1'b0;
      sb       <= 1'b0;
      dz       <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      div_zero <= 1'b0;
    end else begin
      state <= state_n;
      busy  <= state == S_RUN || state == S_FIX;
      done  <= state == S_DONE;
      if (accept) begin
        op_q     <= op;
        cnt      <= '0;
        acc      <= op == OP_MLA ? c : '0;
        mc       <= !is_div(op) ? a : (sdiv_in && b[WIDTH-1]) ? -b : b;
        mp       <= !is_div(op) ? b : (sdiv_in && a[WIDTH-1]) ? -a : a;
        sa       <= sdiv_in && a[WIDTH-1];
        sb       <= sdiv_in && b[WIDTH-1];
        dz       <= is_div(op) && b == '0;
        div_zero <= 1'b0;
      end
      if (state == S_RUN) begin
        acc <= acc_s;
        mc  <= mc_s;
        mp  <= mp_s | {{(WIDTH-1){1'b0}}, q_s};
        cnt <= cnt + 1'b1;
      end
      if (state == S_FIX) result <= fix_res;
      if (state == S_DONE) div_zero <= dz;
    end
  end
endmodule

// File: tb/tb_muldiv_iter.sv
// tb_muldiv_iter: scoreboard bench for muldiv_iter (result, div_zero, latency, busy span)
module tb_muldiv_iter;
  import muldiv_pkg::*;
  logic        clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0, b = '0, c = '0;
  logic        busy, done, div_zero;
  logic [31:0] result;
  int nvec = 0, nerr = 0, cyc = 0, ndone = 0;
  typedef struct {
    logic [31:0] res;
    logic        dz;
    int          k;
    int          lat;
  } exp_t;
  exp_t sb[$];

  muldiv_iter #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b), .c(c),
    .busy(busy), .done(done), .result(result), .div_zero(div_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] x, y, z);
    longint sx, sy, q;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    q  = (y == 0) ? 64'sd0 : sx / sy;
    case (o)
      OP_MUL:  return x * y;
      OP_MLA:  return x * y + z;
      OP_UDIV: return (y == 0) ? 32'd0 : x / y;
      default: return q[31:0];
    endcase
  endfunction

  function automatic int exp_lat(input logic [1:0] o, input logic [31:0] y);
    int l;
    l = 34;
`ifdef MULDIV_EARLY_EXIT_EN
    if (!o[1]) begin
      l = 3;
      for (int i = 0; i < 32; i++) if (y[i]) l = i + 3;
    end
`else
    if (o[1] && y[0]) l = 34;
`endif
    return l;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      ndone++;
      if (sb.size() == 0) check("spurious_done", 1, 0);
      else begin
        e = sb.pop_front();
        check("result", result, e.res);
        check("div_zero", div_zero, e.dz);
        check("latency", cyc - e.k, e.lat);
      end
    end
  end

  task automatic launch(input logic [1:0] o, input logic [31:0] x, y, z, input bit push);
    exp_t e;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y; c = z;
    @(posedge clk);
    #1 start = 1'b0;
    if (push) begin
      e.res = model(o, x, y, z);
      e.dz  = o[1] && y == 0;
      e.k   = cyc;
      e.lat = exp_lat(o, y);
      sb.push_back(e);
    end
  endtask

  task automatic wait_done(input int exp_busy, input bit chk_busy);
    int nb;
    bit got;
    nb = 0;
    got = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (busy) nb++;
      if (done) got = 1;
    end
    check("done_seen", got, 1);
    if (chk_busy) check("busy_cycles", nb, exp_busy);
  endtask

  task automatic run(input logic [1:0] o, input logic [31:0] x, y, z);
    launch(o, x, y, z, 1'b1);
    wait_done(exp_lat(o, y) - 1, 1'b1);
  endtask

  initial begin
    int n0;
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_div_zero", div_zero, 0);
    reset = 1'b0;
    run(OP_MUL, 32'd7, 32'd6, 32'd0);
    run(OP_MLA, 32'hFFFF_FFFF, 32'd2, 32'd5);
    run(OP_UDIV, 32'd100, 32'd7, 32'd0);
    run(OP_SDIV, 32'hFFFF_FF9C, 32'd7, 32'd0);
    run(OP_SDIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
    run(OP_UDIV, 32'd5, 32'd0, 32'd0);
    run(OP_MUL, 32'd3, 32'd3, 32'd0);
    run(OP_SDIV, 32'd100, 32'hFFFF_FFF9, 32'd0);
    run(OP_SDIV, 32'd5, 32'd0, 32'd0);
    run(OP_MUL, 32'd9, 32'd1, 32'd0);
    for (int i = 0; i < 12; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = (i % 3 == 0) ? 32'($urandom_range(1, 20)) : $urandom;
      if (i % 3 == 1 && ro[1]) rb = -rb;
      run(ro, ra, rb, $urandom);
    end
    repeat (3) @(negedge clk);
    check("result_hold", result, model(ro, ra, rb, c));
    n0 = ndone;
    launch(OP_UDIV, 32'd1000, 32'd3, 32'd0, 1'b0);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_mid_busy", busy, 0);
    check("rst_mid_done", done, 0);
    check("rst_mid_result", result, 0);
    repeat (40) @(negedge clk);
    check("rst_mid_no_done", ndone, n0);
    n0 = ndone;
    launch(OP_MUL, 32'd7, 32'd6, 32'd0, 1'b1);
    repeat (5) @(negedge clk);
    start = 1'b1; op = OP_UDIV; a = 32'd1000; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    wait_done(0, 1'b0);
    repeat (40) @(negedge clk);
    check("ignored_start_one_done", ndone, n0 + 1);
    check("ignored_start_result", result, 42);
    @(negedge clk);
    reset = 1'b1; start = 1'b1; op = OP_MUL; a = 32'd2; b = 32'd2;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_start_busy", busy, 0);
    check("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/muldiv_iter.md
Name: muldiv_iter

Overview:
- Iterative multiply / multiply-accumulate / divide unit on the multicycle ARM datapath.
- Responder side of the controller's long-op requests (mla_op, div_op, div_sel).
- Controller pulses start and holds its FSM until done; the result is written back through the ResultSrc mux.
- One operation in flight at a time, with a start/busy/done handshake.

Parameters:
- WIDTH, 32, operand and result width. The iteration count equals WIDTH.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request pulse; sampled only in IDLE
- op  input  2  00 MUL, 01 MLA, 10 UDIV, 11 SDIV
- a  input  WIDTH  multiplicand / dividend (Rn)
- b  input  WIDTH  multiplier / divisor (Rm)
- c  input  WIDTH  accumulate addend (Ra), used by MLA only
- busy  output  1  high while the operation is in RUN or FIX
- done  output  1  one-cycle completion pulse
- result  output  WIDTH  low WIDTH bits of the product, or the quotient
- div_zero  output  1  high with done when a divide had b==0; held until the next accepted start

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset: state=IDLE; busy=0, done=0, result=0, div_zero=0; all internal registers cleared.
- States and transitions: IDLE -> RUN -> FIX -> DONE -> IDLE.
  - IDLE: on start=1 at edge k, latch op, a, b, c and clear the iteration counter. For SDIV, latch |a| and |b| plus both sign bits. Go to RUN.
  - RUN: one iteration per cycle for WIDTH cycles (counter 0..WIDTH-1), then go to FIX.
  - MUL/MLA step (shift-add): if the multiplier LSB is 1, acc += multiplicand. Then multiplicand <<= 1 and multiplier >>= 1.
  - The accumulator initial value is c for MLA and 0 for MUL. Arithmetic is mod 2^WIDTH, so signed and unsigned low halves are identical.
  - DIV step (restoring): rem = {rem, dividend MSB}; dividend <<= 1. If rem >= divisor, then rem -= divisor and the quotient bit is 1.
  - FIX: for SDIV, negate the quotient if sign(a) XOR sign(b). Quotient truncates toward zero; the remainder is discarded.
  - FIX, divide by zero: if b==0 on a divide, result=0 and div_zero=1.
  - FIX: register result. Go to DONE.
  - DONE: done=1 for exactly one cycle, busy=0. Next state IDLE.
- Latency: done is high in the cycle after edge k+WIDTH+2 (34 cycles at WIDTH=32); busy is high for WIDTH+1 cycles.
- start while not in IDLE (including DONE) is ignored; inputs are not re-latched.
- A new start is accepted earliest at the edge after DONE.
- result holds its value from DONE until the next FIX writes it.
- SDIV overflow: 0x80000000 / -1 returns 0x80000000, with no flag.
- Reset mid-operation: the next edge returns to IDLE with no done pulse, and result is cleared to 0.
- Reset and start in the same cycle: reset wins and start is dropped.

Optional Feature:
- Macro: MULDIV_EARLY_EXIT_EN.
- Defined: in RUN for MUL/MLA, when the remaining multiplier register is 0 after an iteration, go to FIX immediately. There is a minimum of 1 RUN cycle, so latency is (index of the highest set bit of b)+1+2, or 3 cycles if b==0. Divide latency is unchanged.
- Not defined: fixed latency WIDTH+2 for all ops, and the zero-detect logic is absent.

Decomposition:
- Package muldiv_pkg holds the op encoding constants (OP_MUL, OP_MLA, OP_UDIV, OP_SDIV) and the state encoding (S_IDLE, S_RUN, S_FIX, S_DONE).
- Sub-module muldiv_step: purely combinational single-iteration logic. Inputs are op class, acc/rem, multiplicand/divisor, multiplier/dividend. It returns the next values plus the quotient bit. The top level owns the FSM, counter and registers.

Test Plan:
- MUL: a=7, b=6, start at edge k -> done=1 after edge k+34, result=42, busy high for exactly 33 cycles.
- MLA: a=0xFFFFFFFF, b=2, c=5 -> result=0x00000003, div_zero=0.
- UDIV 100/7 -> result=14. SDIV a=-100 (0xFFFFFF9C), b=7 -> result=0xFFFFFFF2 (-14). SDIV 0x80000000 / 0xFFFFFFFF -> 0x80000000.
- Divide by zero: UDIV 5/0 -> result=0, div_zero=1 with done. A following MUL 3*3 -> result=9, div_zero=0.
- Reset and ignored start:
  - reset asserted 10 cycles into a UDIV -> busy=0 next cycle, no done pulse, result=0.
  - A start pulsed during RUN is ignored: exactly one done, with the original operands.
- With MULDIV_EARLY_EXIT_EN defined: MUL a=9, b=1 -> done 3 cycles after accept, result=9. UDIV latency is still 34.
